// File: rtl/issue_queue.sv
// Dual-enqueue, dual-issue in-order issue queue between decode and execute.
// Buffers decoded tasks in a ring, tracks pending destinations, issues up to two hazard-free tasks per cycle.
package issue_queue_pkg;
    typedef enum logic [2:0] {
        OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE,
        OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI
    } opcode_t;

    typedef struct packed {
        logic [31:0] pc;
        opcode_t     opcode;
        logic        rd_used;
        logic [4:0]  rd_addr;
        logic        rs1_used;
        logic [4:0]  rs1_addr;
        logic        rs2_used;
        logic [4:0]  rs2_addr;
        logic [31:0] imm;
    } task_t;
endpackage

// Scoreboard hazard check for one issue slot; x0 never hazards.
module iq_hazard (
    input  logic [31:0] busy,
    input  logic        rs1_used,
    input  logic [4:0]  rs1_addr,
    input  logic        rs2_used,
    input  logic [4:0]  rs2_addr,
    input  logic        rd_used,
    input  logic [4:0]  rd_addr,
    output logic        hazard
);
    logic raw1, raw2, waw;

    assign raw1   = rs1_used && (rs1_addr != 5'd0) && busy[rs1_addr];
    assign raw2   = rs2_used && (rs2_addr != 5'd0) && busy[rs2_addr];
    assign waw    = rd_used  && (rd_addr  != 5'd0) && busy[rd_addr];
    assign hazard = raw1 || raw2 || waw;
endmodule

module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  task_t                  TASK_0,
    input  task_t                  TASK_1,
    input  logic                   enq_valid_0,
    input  logic                   enq_valid_1,
    output logic                   enq_ready,
    output task_t                  ISSUE_0,
    output task_t                  ISSUE_1,
    output logic                   issue_valid_0,
    output logic                   issue_valid_1,
    input  logic                   issue_ready_0,
    input  logic                   issue_ready_1,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_addr,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head, tail, head1, tail1;
    logic [31:0]   busy, busy_next;
    task_t         mem [DEPTH];

    task_t [1:0]   slot;
    logic  [1:0]   hz;
    logic          has0, has1;
    logic          rdw0, rdw1, dep, ctl0, mem_pair;
    logic          pop0, pop1, enq0, enq1;
    logic [1:0]    enq_n, pop_n;
    logic [CW-1:0] count_next;

    assign head1   = head + PW'(1);
    assign tail1   = tail + PW'(1);
    assign slot[0] = mem[head];
    assign slot[1] = mem[head1];

    assign has0 = (count != '0);
    assign has1 = (count >= CW'(2));

    // Outputs read as zero when the slot holds no live entry.
    assign ISSUE_0 = has0 ? slot[0] : '0;
    assign ISSUE_1 = has1 ? slot[1] : '0;

    for (genvar g = 0; g < 2; g++) begin : g_hz
        iq_hazard u_hz (
            .busy     (busy),
            .rs1_used (slot[g].rs1_used),
            .rs1_addr (slot[g].rs1_addr),
            .rs2_used (slot[g].rs2_used),
            .rs2_addr (slot[g].rs2_addr),
            .rd_used  (slot[g].rd_used),
            .rd_addr  (slot[g].rd_addr),
            .hazard   (hz[g])
        );
    end

    assign rdw0 = slot[0].rd_used && (slot[0].rd_addr != 5'd0);
    assign rdw1 = slot[1].rd_used && (slot[1].rd_addr != 5'd0);

    // Head+1 may not consume or overwrite what the head is about to produce.
    assign dep = rdw0 &&
                 ((slot[1].rs1_used && (slot[1].rs1_addr == slot[0].rd_addr)) ||
                  (slot[1].rs2_used && (slot[1].rs2_addr == slot[0].rd_addr)) ||
                  (slot[1].rd_used  && (slot[1].rd_addr  == slot[0].rd_addr)));

    assign ctl0     = slot[0].opcode inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
    assign mem_pair = (slot[0].opcode inside {OPC_LOAD, OPC_STORE}) &&
                      (slot[1].opcode inside {OPC_LOAD, OPC_STORE});

    assign issue_valid_0 = has0 && !hz[0];
    assign issue_valid_1 = issue_valid_0 && has1 && !hz[1] && !ctl0 && !mem_pair && !dep;

    assign pop0 = issue_valid_0 && issue_ready_0;
    assign pop1 = pop0 && issue_valid_1 && issue_ready_1;

    // Readiness uses registered occupancy only; same-cycle pops are not credited.
    assign enq_ready = (count <= CW'(DEPTH - 2));
    assign enq0      = enq_ready && enq_valid_0 && !flush;
    assign enq1      = enq0 && enq_valid_1;

    assign enq_n      = {1'b0, enq0} + {1'b0, enq1};
    assign pop_n      = {1'b0, pop0} + {1'b0, pop1};
    assign count_next = count + CW'(enq_n) - CW'(pop_n);

    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_addr] = 1'b0;
        // Sets follow the clear so a same-cycle set wins.
        if (pop0 && rdw0)
            busy_next[slot[0].rd_addr] = 1'b1;
        if (pop1 && rdw1)
            busy_next[slot[1].rd_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + PW'(enq_n);
            count <= count_next;
            busy  <= busy_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq0)
            mem[tail] <= TASK_0;
        if (enq1)
            mem[tail1] <= TASK_1;
    end
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios, then random traffic scored against a queue-based model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int RAND_CYCLES = 3000;

    logic       clk, rst_n;
    task_t      task0, task1, iss0, iss1;
    logic       ev0, ev1, erdy, iv0, iv1, ir0, ir1, wbv, fl;
    logic [4:0] wba;
    logic [$clog2(DEPTH):0] cnt;

    int checks = 0;
    int passes = 0;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .TASK_0        (task0),
        .TASK_1        (task1),
        .enq_valid_0   (ev0),
        .enq_valid_1   (ev1),
        .enq_ready     (erdy),
        .ISSUE_0       (iss0),
        .ISSUE_1       (iss1),
        .issue_valid_0 (iv0),
        .issue_valid_1 (iv1),
        .issue_ready_0 (ir0),
        .issue_ready_1 (ir1),
        .wb_valid      (wbv),
        .wb_addr       (wba),
        .flush         (fl),
        .count         (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic task_t mk(input opcode_t op, input logic rdu, input logic [4:0] rd,
                                 input logic r1u, input logic [4:0] r1,
                                 input logic r2u, input logic [4:0] r2, input int pc);
        task_t t;
        t.pc = 32'(pc); t.opcode = op;
        t.rd_used = rdu;  t.rd_addr = rd;
        t.rs1_used = r1u; t.rs1_addr = r1;
        t.rs2_used = r2u; t.rs2_addr = r2;
        t.imm = 32'(pc) ^ 32'h5a5a_0000;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ev0 = 0; ev1 = 0; wbv = 0; wba = 0; fl = 0;
        task0 = '0; task1 = '0;
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit v0; bit v1; int cnt; bit rdy; } exp_t;
    exp_t    exp_q[$];
    task_t   ord_q[$];
    task_t   mq[$];
    bit [31:0] mbusy;
    bit      running = 0;

    function automatic bit writes(input task_t t);
        return t.rd_used && t.rd_addr != 0;
    endfunction

    function automatic bit m_hz(input task_t t);
        return (t.rs1_used && mbusy[t.rs1_addr]) || (t.rs2_used && mbusy[t.rs2_addr]) ||
               (writes(t) && mbusy[t.rd_addr]);
    endfunction

    function automatic bit is_mem(input task_t t);
        return t.opcode == OPC_LOAD || t.opcode == OPC_STORE;
    endfunction

    function automatic bit pair_ok(input task_t a, input task_t b);
        bit clash;
        if (a.opcode == OPC_BRANCH || a.opcode == OPC_JAL || a.opcode == OPC_JALR) return 0;
        if (is_mem(a) && is_mem(b)) return 0;
        clash = writes(a) && ((b.rs1_used && b.rs1_addr == a.rd_addr) ||
                              (b.rs2_used && b.rs2_addr == a.rd_addr) ||
                              (b.rd_used  && b.rd_addr  == a.rd_addr));
        return !clash;
    endfunction

    function automatic task_t rtask(input int id);
        task_t t;
        t = mk(opcode_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), id);
        t.imm = $urandom;
        return t;
    endfunction

    // Monitor: compares DUT outputs with the model's per-cycle expectation and issue order.
    initial begin
        exp_t  e;
        task_t t;
        forever begin
            @(negedge clk); #2;
            if (running) begin
                if (exp_q.size() == 0) begin
                    chk("exp_queue_empty", 128'(0), 128'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_valid_0", 128'(iv0), 128'(e.v0));
                    chk("issue_valid_1", 128'(iv1), 128'(e.v1));
                    chk("count", 128'(cnt), 128'(e.cnt));
                    chk("enq_ready", 128'(erdy), 128'(e.rdy));
                end
                if (iv0 && ir0 && !fl) begin
                    if (ord_q.size() == 0) chk("order_empty_0", 128'(0), 128'(1));
                    else begin t = ord_q.pop_front(); chk("issue0_task", 128'(iss0), 128'(t)); end
                    if (iv1 && ir1) begin
                        if (ord_q.size() == 0) chk("order_empty_1", 128'(0), 128'(1));
                        else begin t = ord_q.pop_front(); chk("issue1_task", 128'(iss1), 128'(t)); end
                    end
                end
            end
        end
    end

    initial begin
        exp_t  e;
        task_t t;
        int    npop;
        bit    rdy;
        int    id;

        clk = 0; rst_n = 0; ir0 = 0; ir1 = 0;
        idle();
        #3;
        chk("reset_count", 128'(cnt), 128'(0));
        chk("reset_enq_ready", 128'(erdy), 128'(1));
        chk("reset_iv0", 128'(iv0), 128'(0));
        chk("reset_iv1", 128'(iv1), 128'(0));
        chk("reset_issue0", 128'(iss0), 128'(0));
        #9 rst_n = 1;

        // Dual enqueue of independent ops, both issue next cycle.
        task0 = mk(OPC_OP, 1, 5, 0, 0, 0, 0, 100);
        task1 = mk(OPC_OP, 1, 6, 0, 0, 0, 0, 101);
        ev0 = 1; ev1 = 1; ir0 = 1; ir1 = 1;
        tick(); ev0 = 0; ev1 = 0;
        chk("dual_count", 128'(cnt), 128'(2));
        chk("dual_iv0", 128'(iv0), 128'(1));
        chk("dual_iv1", 128'(iv1), 128'(1));
        chk("dual_pc0", 128'(iss0.pc), 128'(100));
        chk("dual_pc1", 128'(iss1.pc), 128'(101));
        tick();
        chk("dual_drained", 128'(cnt), 128'(0));

        // x5 is now busy: a reader of x5 must wait for its writeback.
        task0 = mk(OPC_OP, 1, 8, 1, 5, 0, 0, 102);
        task1 = mk(OPC_OP, 1, 9, 1, 1, 0, 0, 103);
        ev0 = 1; ev1 = 1;
        tick(); ev0 = 0; ev1 = 0;
        chk("busy5_blocks", 128'(iv0), 128'(0));
        wbv = 1; wba = 5;
        tick();
        chk("wb5_unblocks_v0", 128'(iv0), 128'(1));
        chk("wb5_unblocks_v1", 128'(iv1), 128'(1));
        wba = 6;
        tick();
        chk("busy_pair_drained", 128'(cnt), 128'(0));
        wba = 8; tick();
        wba = 9; tick();
        wbv = 0;

        // Intra-pair RAW.
        task0 = mk(OPC_OPIMM, 1, 5, 1, 0, 0, 0, 110);
        task1 = mk(OPC_OP, 1, 7, 1, 5, 1, 1, 111);
        ev0 = 1; ev1 = 1;
        tick(); ev0 = 0; ev1 = 0;
        chk("raw_pair_v0", 128'(iv0), 128'(1));
        chk("raw_pair_v1", 128'(iv1), 128'(0));
        tick();
        chk("raw_count", 128'(cnt), 128'(1));
        chk("raw_blocked", 128'(iv0), 128'(0));
        chk("raw_head_pc", 128'(iss0.pc), 128'(111));
        wbv = 1; wba = 5;
        tick(); wbv = 0;
        chk("raw_released", 128'(iv0), 128'(1));
        tick();
        chk("raw_drained", 128'(cnt), 128'(0));
        wbv = 1; wba = 7; tick(); wbv = 0;

        // Branch at head never pairs.
        task0 = mk(OPC_BRANCH, 0, 0, 1, 1, 1, 2, 120);
        task1 = mk(OPC_OP, 1, 10, 0, 0, 0, 0, 121);
        ev0 = 1; ev1 = 1;
        tick(); ev0 = 0; ev1 = 0;
        chk("branch_v0", 128'(iv0), 128'(1));
        chk("branch_v1", 128'(iv1), 128'(0));
        tick();
        chk("branch_next_v0", 128'(iv0), 128'(1));
        chk("branch_next_pc", 128'(iss0.pc), 128'(121));
        tick();
        chk("branch_drained", 128'(cnt), 128'(0));
        wbv = 1; wba = 10; tick(); wbv = 0;

        // Fill to full, attempt overflow, drain in order.
        ir0 = 0; ir1 = 0;
        for (int k = 0; k < 4; k++) begin
            task0 = mk(OPC_OP, 0, 0, 0, 0, 0, 0, 200 + 2 * k);
            task1 = mk(OPC_OP, 0, 0, 0, 0, 0, 0, 201 + 2 * k);
            ev0 = 1; ev1 = 1;
            chk("fill_ready", 128'(erdy), 128'(1));
            tick();
        end
        task0 = mk(OPC_OP, 0, 0, 0, 0, 0, 0, 300);
        chk("full_count", 128'(cnt), 128'(8));
        chk("full_not_ready", 128'(erdy), 128'(0));
        tick(); ev0 = 0; ev1 = 0;
        chk("full_ignored", 128'(cnt), 128'(8));
        ir0 = 1; ir1 = 1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc0", 128'(iss0.pc), 128'(200 + 2 * k));
            chk("drain_pc1", 128'(iss1.pc), 128'(201 + 2 * k));
            tick();
        end
        chk("drain_empty", 128'(cnt), 128'(0));

        // Asynchronous reset with five entries held.
        ir0 = 0; ir1 = 0;
        task0 = mk(OPC_OP, 0, 0, 0, 0, 0, 0, 310);
        task1 = mk(OPC_OP, 0, 0, 0, 0, 0, 0, 311);
        ev0 = 1; ev1 = 1; tick(); tick();
        ev1 = 0; tick(); ev0 = 0;
        chk("pre_reset_count", 128'(cnt), 128'(5));
        #3 rst_n = 0;
        #1;
        chk("async_reset_count", 128'(cnt), 128'(0));
        chk("async_reset_ready", 128'(erdy), 128'(1));
        chk("async_reset_iv0", 128'(iv0), 128'(0));
        #2 rst_n = 1;
        tick();

        // Flush collides with enqueue, pop and writeback.
        task0 = mk(OPC_OP, 1, 12, 0, 0, 0, 0, 400);
        ev0 = 1; tick(); ev0 = 0;
        chk("flush_pre_v0", 128'(iv0), 128'(1));
        fl = 1; ev0 = 1; ev1 = 1; ir0 = 1; ir1 = 1; wbv = 1; wba = 3;
        task0 = mk(OPC_OP, 1, 13, 0, 0, 0, 0, 401);
        task1 = mk(OPC_OP, 1, 14, 0, 0, 0, 0, 402);
        tick();
        idle(); ir0 = 0; ir1 = 0;
        chk("flush_count", 128'(cnt), 128'(0));
        chk("flush_iv0", 128'(iv0), 128'(0));
        task0 = mk(OPC_OP, 1, 20, 1, 12, 0, 0, 403);
        task1 = mk(OPC_OP, 0, 0, 1, 13, 1, 14, 404);
        ev0 = 1; ev1 = 1; tick(); ev0 = 0; ev1 = 0;
        chk("flush_no_busy_v0", 128'(iv0), 128'(1));
        chk("flush_no_busy_v1", 128'(iv1), 128'(1));
        chk("flush_refill_count", 128'(cnt), 128'(2));

        // Random traffic against the model from a clean reset.
        rst_n = 0; #3 rst_n = 1;
        mq.delete(); ord_q.delete(); exp_q.delete(); mbusy = '0;
        id = 1000;
        @(negedge clk);
        running = 1;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if (c != 0) @(negedge clk);
            task0 = rtask(id); task1 = rtask(id + 1);
            ev0 = ($urandom_range(0, 9) < 6);
            ev1 = 1'($urandom_range(0, 1));
            ir0 = ($urandom_range(0, 9) < 7);
            ir1 = ($urandom_range(0, 9) < 7);
            wbv = ($urandom_range(0, 9) < 4);
            wba = 5'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 99) < 2);
            #1;
            rdy = (mq.size() <= DEPTH - 2);
            e.cnt = mq.size();
            e.rdy = rdy;
            e.v0 = (mq.size() >= 1) && !m_hz(mq[0]);
            e.v1 = e.v0 && (mq.size() >= 2) && !m_hz(mq[1]) && pair_ok(mq[0], mq[1]);
            exp_q.push_back(e);
            if (fl) begin
                mq.delete(); ord_q.delete(); mbusy = '0;
            end else begin
                npop = (e.v0 && ir0) ? ((e.v1 && ir1) ? 2 : 1) : 0;
                if (wbv) mbusy[wba] = 1'b0;
                for (int p = 0; p < npop; p++) begin
                    t = mq.pop_front();
                    if (writes(t)) mbusy[t.rd_addr] = 1'b1;
                end
                if (rdy && ev0) begin
                    mq.push_back(task0); ord_q.push_back(task0); id++;
                    if (ev1) begin mq.push_back(task1); ord_q.push_back(task1); id++; end
                end
            end
        end
        @(negedge clk);
        running = 0;
        idle();
        chk("exp_queue_consumed", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
